// File: rtl/movwide_sequencer_pkg.sv
// Shared types for the MOVZ/MOVK wide-move sequencer.
// Ctrl codes match the sign extender and the main control unit.
package movwide_sequencer_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  localparam logic [2:0] MOVW_CTRL_BASE = 3'b100;
  localparam int HW_COUNT = 4;

  typedef enum logic [2:0] {
    EXT_MOVW0  = 3'b100,
    EXT_MOVW16 = 3'b101,
    EXT_MOVW32 = 3'b110,
    EXT_MOVW48 = 3'b111
  } ext_ctrl_t;

  typedef struct packed {
    logic [63:0] value;
    logic [4:0]  rd;
  } movw_req_t;

  // An all-zero constant still needs one MOVZ #0.
  function automatic logic [3:0] hw_mask(
    input logic [63:0] v
  );
    logic [3:0] m;
    for (int i = 0; i < HW_COUNT; i++)
      m[i] = (v[16*i +: 16] != 16'h0);
    if (m == 4'b0000)
      m = 4'b0001;
    return m;
  endfunction

  function automatic ext_ctrl_t movw_ctrl(
    input logic [1:0] idx
  );
    return ext_ctrl_t'(MOVW_CTRL_BASE | {1'b0, idx});
  endfunction

endpackage

// File: rtl/movwide_sequencer_if.sv
// Request and micro-op beat handshakes of the wide-move sequencer.
// master = sequencer side, slave = fetch/datapath side.
interface movwide_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_value;
  logic [4:0]  req_rd;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_ctrl;
  logic [15:0] out_imm16;
  logic [4:0]  out_rd;
  logic        out_keep;
  logic        out_last;

  modport master (
    input  req_valid,
    input  req_value,
    input  req_rd,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_ctrl,
    output out_imm16,
    output out_rd,
    output out_keep,
    output out_last
  );

  modport slave (
    output req_valid,
    output req_value,
    output req_rd,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_ctrl,
    input  out_imm16,
    input  out_rd,
    input  out_keep,
    input  out_last
  );
endinterface

// File: rtl/movwide_hw_pick.sv
// Finds the lowest set mask bit above idx (or the lowest overall
// when from_start is set); none flags that no such bit exists.
module movwide_hw_pick
  import movwide_sequencer_pkg::*;
(
  input  logic [3:0] mask,
  input  logic [1:0] idx,
  input  logic       from_start,
  output logic [1:0] nxt,
  output logic       none
);

  always_comb begin
    nxt  = 2'd0;
    none = 1'b1;
    for (int i = HW_COUNT - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || i > int'(idx))) begin
        nxt  = 2'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/movwide_sequencer.sv
// 64-bit constant load -> minimal ascending MOVZ/MOVK beat stream.
// MOVWIDE_BACK2BACK_EN: accept the next request on the last beat.
module movwide_sequencer
  import movwide_sequencer_pkg::*;
(
  input logic                CLK,
  input logic                resetl,
  movwide_sequencer_if.master bus,
  output logic               busy
);

  state_t    state_q, state_d;
  movw_req_t req_q, req_d;
  logic [3:0] mask_q, mask_d;
  logic [1:0] idx_q, idx_d;
  logic       first_q, first_d;

  logic [3:0] new_mask;
  logic [1:0] first_idx;
  logic       first_none;
  logic [1:0] adv_idx;
  logic       adv_none;

  logic emit;
  logic last;
  logic fire;
  logic rdy;
  logic accept;

  assign new_mask = hw_mask(bus.req_value);

  movwide_hw_pick u_pick_first (
    .mask       (new_mask),
    .idx        (2'd0),
    .from_start (1'b1),
    .nxt        (first_idx),
    .none       (first_none)
  );

  movwide_hw_pick u_pick_adv (
    .mask       (mask_q),
    .idx        (idx_q),
    .from_start (1'b0),
    .nxt        (adv_idx),
    .none       (adv_none)
  );

  assign emit = (state_q == S_EMIT);
  assign last = adv_none;
  assign fire = emit && bus.out_ready;

`ifdef MOVWIDE_BACK2BACK_EN
  assign rdy = resetl && (!emit || (fire && last));
`else
  assign rdy = resetl && !emit;
`endif

  assign accept = bus.req_valid && rdy;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    first_d = first_q;
    if (fire && !last) begin
      idx_d   = adv_idx;
      first_d = 1'b0;
    end else if (accept) begin
      state_d     = S_EMIT;
      req_d.value = bus.req_value;
      req_d.rd    = bus.req_rd;
      mask_d      = new_mask;
      idx_d       = first_none ? 2'd0 : first_idx;
      first_d     = 1'b1;
    end else if (fire) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      mask_q  <= 4'b0000;
      idx_q   <= 2'd0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      first_q <= first_d;
    end
  end

  // Gate beat fields so everything reads 0 outside EMIT.
  assign bus.req_ready = rdy;
  assign bus.out_valid = emit;
  assign bus.out_ctrl  = emit ? movw_ctrl(idx_q) : 3'b000;
  assign bus.out_imm16 =
    emit ? req_q.value[{idx_q, 4'b0000} +: 16] : 16'h0;
  assign bus.out_rd    = emit ? req_q.rd : 5'd0;
  assign bus.out_keep  = emit && !first_q;
  assign bus.out_last  = emit && last;
  assign busy          = emit;

endmodule

// File: tb/tb_movwide_sequencer.sv
// Randomized check of movwide_sequencer against a beat-list model.
// Build with or without MOVWIDE_BACK2BACK_EN.
module tb_movwide_sequencer;

  logic clk = 1'b0;
  logic resetl = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  movwide_sequencer_if bus ();

  movwide_sequencer dut (
    .CLK    (clk),
    .resetl (resetl),
    .bus    (bus.master),
    .busy   (busy)
  );

  typedef struct {
    logic [2:0]  ctrl;
    logic [15:0] imm;
    logic [4:0]  rd;
    logic        keep;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] stim_val[$];
  logic [4:0]  stim_rd[$];

  int   total = 0;
  int   bad = 0;
  int   rdy_mode = 0;
  int   cyc = 0;
  logic accepted = 1'b0;
  logic prev_stall = 1'b0;
  beat_t held;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Spec rule: one beat per nonzero halfword, ascending, first is MOVZ.
  function automatic void model_push(logic [63:0] v, logic [4:0] rd);
    int hws[$];
    for (int i = 0; i < 4; i++)
      if (v[16*i +: 16] != 16'h0) hws.push_back(i);
    if (hws.size() == 0) hws.push_back(0);
    foreach (hws[k]) begin
      beat_t b;
      b.ctrl = 3'(4 + hws[k]);
      b.imm  = v[16*hws[k] +: 16];
      b.rd   = rd;
      b.keep = (k != 0);
      b.last = (k == hws.size() - 1);
      exp_q.push_back(b);
    end
  endfunction

  task automatic drive();
    if (accepted) begin
      bus.req_valid = 1'b0;
      accepted = 1'b0;
    end
    if (!bus.req_valid && stim_val.size() > 0 &&
        (rdy_mode != 1 || $urandom_range(0, 1) == 1)) begin
      bus.req_valid = 1'b1;
      bus.req_value = stim_val.pop_front();
      bus.req_rd    = stim_rd.pop_front();
    end
    case (rdy_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = (cyc % 3 == 0);
    endcase
    cyc++;
  endtask

  task automatic eval();
    logic exp_busy, exp_rdy;
    #1;
    exp_busy = (exp_q.size() != 0);
    chk("out_valid", bus.out_valid, exp_busy);
    chk("busy", busy, exp_busy);
    exp_rdy = !exp_busy;
`ifdef MOVWIDE_BACK2BACK_EN
    if (exp_busy && bus.out_ready && exp_q[0].last) exp_rdy = 1'b1;
`endif
    chk("req_ready", bus.req_ready, exp_rdy);
    if (prev_stall) begin
      chk("hold_ctrl", bus.out_ctrl, held.ctrl);
      chk("hold_imm", bus.out_imm16, held.imm);
      chk("hold_rd", bus.out_rd, held.rd);
      chk("hold_keep", bus.out_keep, held.keep);
      chk("hold_last", bus.out_last, held.last);
    end
    if (exp_busy && bus.out_valid) begin
      chk("ctrl", bus.out_ctrl, exp_q[0].ctrl);
      chk("imm16", bus.out_imm16, exp_q[0].imm);
      chk("rd", bus.out_rd, exp_q[0].rd);
      chk("keep", bus.out_keep, exp_q[0].keep);
      chk("last", bus.out_last, exp_q[0].last);
    end
    if (exp_busy && bus.out_ready) void'(exp_q.pop_front());
    prev_stall = bus.out_valid && !bus.out_ready;
    held.ctrl = bus.out_ctrl;
    held.imm  = bus.out_imm16;
    held.rd   = bus.out_rd;
    held.keep = bus.out_keep;
    held.last = bus.out_last;
    if (bus.req_valid && bus.req_ready) begin
      model_push(bus.req_value, bus.req_rd);
      accepted = 1'b1;
    end
  endtask

  task automatic run(int mode, int max_cyc);
    logic done;
    rdy_mode = mode;
    cyc = 0;
    done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      drive();
      eval();
      @(negedge clk);
      done = stim_val.size() == 0 && exp_q.size() == 0 &&
             (!bus.req_valid || accepted);
    end
    if (!done) chk("timeout", 1'b1, 1'b0);
  endtask

  task automatic add(logic [63:0] v, logic [4:0] rd);
    stim_val.push_back(v);
    stim_rd.push_back(rd);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_ctrl"}, bus.out_ctrl, 3'b000);
    chk({tag, "_imm"}, bus.out_imm16, 16'h0);
    chk({tag, "_rd"}, bus.out_rd, 5'd0);
    chk({tag, "_keep"}, bus.out_keep, 1'b0);
    chk({tag, "_last"}, bus.out_last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rdy"}, bus.req_ready, 1'b0);
  endtask

  initial begin
    logic [63:0] v;
    bus.req_valid = 1'b0;
    bus.req_value = 64'h0;
    bus.req_rd    = 5'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    resetl = 1'b1;
    #1;
    chk("rst_release_rdy", bus.req_ready, 1'b1);
    @(negedge clk);

    add(64'h0, 5'd3);
    add(64'h1234_0000_0000_ABCD, 5'd7);
    add(64'h0000_5678_0000_0000, 5'd9);
    run(0, 40);

    add(64'hFFFF_FFFF_FFFF_FFFF, 5'd1);
    run(2, 60);

    add(64'h0000_0001_0000_0002, 5'd4);
    add(64'h0003_0000_0004_0005, 5'd5);
    run(0, 40);

    for (int n = 0; n < 60; n++) begin
      v = {$urandom, $urandom};
      for (int h = 0; h < 4; h++)
        if ($urandom_range(0, 2) == 0) v[16*h +: 16] = 16'h0;
      add(v, 5'($urandom_range(0, 31)));
    end
    run(1, 2000);

    add(64'hFFFF_FFFF_FFFF_FFFF, 5'd2);
    rdy_mode = 0;
    for (int c = 0; c < 10 && exp_q.size() != 3; c++) begin
      drive();
      eval();
      @(negedge clk);
    end
    chk("mid_seq_beats_left", 64'(exp_q.size()), 64'd3);
    resetl = 1'b0;
    #1;
    chk_zero("midrst");
    exp_q.delete();
    stim_val.delete();
    stim_rd.delete();
    bus.req_valid = 1'b0;
    accepted = 1'b0;
    prev_stall = 1'b0;
    @(posedge clk);
    #2;
    resetl = 1'b1;
    #1;
    chk("midrst_release_rdy", bus.req_ready, 1'b1);
    @(negedge clk);
    run(0, 6);
    for (int c = 0; c < 4; c++) begin
      drive();
      eval();
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/movwide_sequencer.md
# movwide_sequencer

Sequencer that turns a 64-bit constant load request into the minimal ordered stream of MOVZ/MOVK wide-move micro-ops for the LEGv8 datapath. Each beat carries the 16-bit immediate, the destination register and the 3-bit sign-extender control code that selects the MOVZ shift (0/16/32/48). The block sits between instruction fetch/expansion and the datapath, upstream of the sign extender, and drives its Ctrl field with codes 3'b100–3'b111.

## Interface
- No parameters. Widths are fixed by the ISA.
- CLK  in  1  rising-edge clock
- resetl  in  1  asynchronous, active-low reset
- req_valid  in  1  constant-load request present
- req_ready  out  1  sequencer can accept a request
- req_value  in  64  constant to materialise
- req_rd  in  5  destination register
- out_valid  out  1  micro-op beat valid
- out_ready  in  1  datapath accepts beat
- out_ctrl  out  3  sign-extender Ctrl: 3'b100 shift 0, 3'b101 shift 16, 3'b110 shift 32, 3'b111 shift 48
- out_imm16  out  16  halfword, placed on Imm26[20:5] by the issuer
- out_rd  out  5  destination register
- out_keep  out  1  0 = MOVZ (clear others), 1 = MOVK (keep others)
- out_last  out  1  final beat of the sequence
- busy  out  1  sequence in progress (state != IDLE)

## Operation
- States: IDLE, EMIT.
- IDLE: req_ready=1. On req_valid&&req_ready: latch value and rd, compute mask[3:0] with mask[i] = (value[16i+15:16i] != 0). If mask==0, force mask=4'b0001 so that the load emits MOVZ #0. Set idx = lowest set bit of mask, first=1. Go to EMIT.
- EMIT: out_valid=1, out_ctrl={1'b1,idx}, out_imm16=value halfword idx, out_keep=!first, out_last = no set mask bit above idx.
- On an out_valid&&out_ready beat: if out_last, go to IDLE. Otherwise set idx = next set bit above idx, first=0, and stay in EMIT.
- Outputs are stable while out_valid && !out_ready. The stream is never withdrawn except by reset.
- Zero halfwords are skipped. The beat count is popcount(mask) over the range 1..4. The first beat is always MOVZ and the beats are emitted in ascending shift order.
- Reset value of every output is 0 while resetl=0. req_ready rises in the first cycle after deassertion. Reset in the middle of a sequence drops the remaining beats with no partial-completion signal.

## Timing
- Request handshake at edge N drives the first beat valid from N+1. Beats are registered, and there is no combinational path from any req_* input to out_*.
- With out_ready held at 1 there is one beat per cycle, and a k-beat sequence occupies cycles N+1..N+k.
- Without MOVWIDE_BACK2BACK_EN there is one idle cycle after the last beat, so the next request is accepted at edge N+k+1 at the earliest.
- out_ready → req_ready is the only combinational path, and only when the macro is defined.

## Configuration
- MOVWIDE_BACK2BACK_EN defined: req_ready = (state==IDLE) || (out_valid && out_ready && out_last). A request accepted in the last-beat cycle loads directly into EMIT, which gives zero-bubble back-to-back sequences.
- MOVWIDE_BACK2BACK_EN undefined: req_ready = (state==IDLE) only.

## Structure
- A shared package holds:
  - the state enum (IDLE, EMIT);
  - the constants MOVW_CTRL_BASE=3'b100 and HW_COUNT=4;
  - the Ctrl encoding, which is shared with the sign extender and the main control unit.
- One sub-module, movwide_hw_pick: a combinational "next set bit above index" finder (4-bit mask, 2-bit idx in, 2-bit next idx and a none flag out). It is used both for the first-bit selection (index = −1 form) and for advancing.

## Test plan
- req_value=64'h0 with out_ready=1 → exactly one beat: ctrl=100, imm=0000, keep=0, last=1.
- req_value=64'h1234_0000_0000_ABCD, rd=7 → two beats:
  - ctrl=100, imm=ABCD, keep=0;
  - ctrl=111, imm=1234, keep=1, last=1.
  - out_rd=7 on both beats.
- req_value=64'h0000_5678_0000_0000 → one beat: ctrl=110, imm=5678, keep=0, last=1.
- req_value=64'hFFFF_FFFF_FFFF_FFFF with out_ready toggling 1,0,0,1,… → four beats (ctrl 100..111) with outputs stable across the stalls; req_ready=0 throughout and busy=1.
- Two back-to-back requests with out_ready=1:
  - macro undefined: one bubble between sequences;
  - macro defined: the second request's first beat appears in the cycle after the first request's last beat.
- resetl pulsed low during the second beat of a 4-beat sequence → all outputs 0 immediately; req_ready=1 on the first cycle after release; no further beats.
